hit_life_manager: RTL and testbench

//  Downstream consumer of the object-pair collision flag. Samples the combinational overlap

---
 rtl/hit_life_manager_pkg.sv | 17 +
 rtl/hit_life_manager_frame_down_counter.sv | 31 +++
 rtl/hit_life_manager.sv | 168 ++++++++++++++++
 tb/tb_hit_life_manager.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/hit_life_manager_pkg.sv
// Shared definitions for the hit/lives manager and its consumers.
// State encodings are exported so HUD and render stages decode them identically.
package hit_life_manager_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PLAY     = 2'd1,
        ST_INVINC   = 2'd2,
        ST_GAMEOVER = 2'd3
    } state_t;

    // A game is running; start requests are ignored in these states.
    function automatic logic is_ingame(input state_t s);
        return (s == ST_PLAY) || (s == ST_INVINC);
    endfunction

endpackage

// File: rtl/hit_life_manager_frame_down_counter.sv
// Frame-tick down counter: synchronous load, decrement on tick, zero flag.
// Ports: i_Clk, i_Rst (async high), i_Load, i_LoadVal, i_Tick -> o_Count, o_Zero.
module frame_down_counter #(
    parameter int W = 7
) (
    input  logic         i_Clk,
    input  logic         i_Rst,
    input  logic         i_Load,
    input  logic [W-1:0] i_LoadVal,
    input  logic         i_Tick,
    output logic [W-1:0] o_Count,
    output logic         o_Zero
);

    logic [W-1:0] r_Count;

    // Load wins over decrement; the count saturates at zero.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_Count <= '0;
        end else if (i_Load) begin
            r_Count <= i_LoadVal;
        end else if (i_Tick && (r_Count != '0)) begin
            r_Count <= r_Count - W'(1);
        end
    end

    assign o_Count = r_Count;
    assign o_Zero  = (r_Count == '0);

endmodule

// File: rtl/hit_life_manager.sv
// Turns the per-frame collision flag into hit events, lives, invincibility and game over.
// Ports: i_Clk, i_Rst (async high), i_FrameTick, i_IsCollision, i_GameStart ->
//   o_HitPulse, o_Lives[LIVES_W], o_Invincible, o_GameOver, o_SpriteOn.
// Option: define HIT_BLINK_EN to blink the sprite during invincibility.
import hit_life_manager_pkg::*;

module hit_life_manager #(
    parameter int INIT_LIVES    = 3,
    parameter int LIVES_W       = 3,
    parameter int INVINC_FRAMES = 60,
    parameter int INVINC_W      = 7,
    parameter int BLINK_PERIOD  = 4
) (
    input  logic               i_Clk,
    input  logic               i_Rst,
    input  logic               i_FrameTick,
    input  logic               i_IsCollision,
    input  logic               i_GameStart,
    output logic               o_HitPulse,
    output logic [LIVES_W-1:0] o_Lives,
    output logic               o_Invincible,
    output logic               o_GameOver,
    output logic               o_SpriteOn
);

    if (INIT_LIVES < 1 || INIT_LIVES > (2**LIVES_W - 1)) begin : g_bad_lives
        $error("INIT_LIVES out of range for LIVES_W");
    end
    if (INVINC_FRAMES < 1 || INVINC_FRAMES > (2**INVINC_W - 1)) begin : g_bad_invinc
        $error("INVINC_FRAMES out of range for INVINC_W");
    end
    if (BLINK_PERIOD < 1) begin : g_bad_blink
        $error("BLINK_PERIOD must be at least 1");
    end

    state_t               r_State;
    state_t               w_StateNxt;
    logic                 r_HitPulse;
    logic [LIVES_W-1:0]   r_Lives;
    logic [LIVES_W-1:0]   w_LivesNxt;
    logic                 r_Invincible;
    logic                 r_GameOver;

    logic                 w_InPlay;
    logic                 w_InInv;
    logic                 w_Start;
    logic                 w_Hit;
    logic                 w_Fatal;
    logic                 w_InvLoad;
    logic                 w_InvEnd;
    logic [INVINC_W-1:0]  w_InvCount;
    logic                 w_InvZero;

    assign w_InPlay  = (r_State == ST_PLAY);
    assign w_InInv   = (r_State == ST_INVINC);
    assign w_Start   = i_GameStart && !is_ingame(r_State);
    // Collision is only sampled on a frame tick, so glitches between ticks are invisible.
    assign w_Hit     = w_InPlay && i_FrameTick && i_IsCollision
                       && (r_Lives != '0);
    assign w_Fatal   = w_Hit && (r_Lives == LIVES_W'(1));
    assign w_InvLoad = w_Hit && !w_Fatal;
    // The zero term only recovers from an impossible empty window.
    assign w_InvEnd  = w_InInv
                       && ((i_FrameTick && (w_InvCount == INVINC_W'(1)))
                           || w_InvZero);

    frame_down_counter #(
        .W (INVINC_W)
    ) u_invinc_cnt (
        .i_Clk     (i_Clk),
        .i_Rst     (i_Rst),
        .i_Load    (w_InvLoad),
        .i_LoadVal (INVINC_W'(INVINC_FRAMES)),
        .i_Tick    (i_FrameTick && w_InInv),
        .o_Count   (w_InvCount),
        .o_Zero    (w_InvZero)
    );

    always_comb begin
        w_StateNxt = r_State;
        w_LivesNxt = r_Lives;
        unique case (r_State)
            ST_IDLE, ST_GAMEOVER: begin
                if (w_Start) begin
                    w_StateNxt = ST_PLAY;
                    w_LivesNxt = LIVES_W'(INIT_LIVES);
                end
            end
            ST_PLAY: begin
                if (w_Hit) begin
                    w_LivesNxt = r_Lives - LIVES_W'(1);
                    w_StateNxt = w_Fatal ? ST_GAMEOVER : ST_INVINC;
                end
            end
            ST_INVINC: begin
                if (w_InvEnd) begin
                    w_StateNxt = ST_PLAY;
                end
            end
            default: begin
                w_StateNxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_State      <= ST_IDLE;
            r_HitPulse   <= 1'b0;
            r_Lives      <= LIVES_W'(INIT_LIVES);
            r_Invincible <= 1'b0;
            r_GameOver   <= 1'b0;
        end else begin
            r_State      <= w_StateNxt;
            r_HitPulse   <= w_Hit;
            r_Lives      <= w_LivesNxt;
            r_Invincible <= (w_StateNxt == ST_INVINC);
            r_GameOver   <= (w_StateNxt == ST_GAMEOVER);
        end
    end

`ifdef HIT_BLINK_EN
    localparam int BLINK_W = $clog2(BLINK_PERIOD + 1);

    logic               r_SpriteOn;
    logic [BLINK_W-1:0] w_BlinkCount;
    logic               w_BlinkZero;
    logic               w_BlinkWrap;

    // One half-period has elapsed: toggle and start the next one.
    assign w_BlinkWrap = w_InInv && i_FrameTick
                         && ((w_BlinkCount == BLINK_W'(1)) || w_BlinkZero);

    frame_down_counter #(
        .W (BLINK_W)
    ) u_blink_cnt (
        .i_Clk     (i_Clk),
        .i_Rst     (i_Rst),
        .i_Load    (w_InvLoad || w_BlinkWrap),
        .i_LoadVal (BLINK_W'(BLINK_PERIOD)),
        .i_Tick    (i_FrameTick && w_InInv),
        .o_Count   (w_BlinkCount),
        .o_Zero    (w_BlinkZero)
    );

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_SpriteOn <= 1'b1;
        end else if (w_StateNxt != ST_INVINC) begin
            r_SpriteOn <= 1'b1;
        end else if (w_InvLoad) begin
            r_SpriteOn <= 1'b0;
        end else if (w_BlinkWrap) begin
            r_SpriteOn <= ~r_SpriteOn;
        end
    end

    assign o_SpriteOn = r_SpriteOn;
`else
    assign o_SpriteOn = 1'b1;
`endif

    assign o_HitPulse   = r_HitPulse;
    assign o_Lives      = r_Lives;
    assign o_Invincible = r_Invincible;
    assign o_GameOver   = r_GameOver;

endmodule

// File: tb/tb_hit_life_manager.sv
// Randomized and directed bench for hit_life_manager against a behavioural model.
// Honors HIT_BLINK_EN the same way the design does.
module tb_hit_life_manager;

    localparam int INIT_LIVES = 3;
    localparam int LIVES_W    = 3;
    localparam int INV_FRAMES = 60;
    localparam int INV_W      = 7;
    localparam int BLINK_P    = 4;
`ifdef HIT_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               tick;
    logic               coll;
    logic               start;
    logic               hit_pulse;
    logic [LIVES_W-1:0] lives;
    logic               invinc;
    logic               game_over;
    logic               sprite_on;

    hit_life_manager #(
        .INIT_LIVES    (INIT_LIVES),
        .LIVES_W       (LIVES_W),
        .INVINC_FRAMES (INV_FRAMES),
        .INVINC_W      (INV_W),
        .BLINK_PERIOD  (BLINK_P)
    ) dut (
        .i_Clk         (clk),
        .i_Rst         (rst),
        .i_FrameTick   (tick),
        .i_IsCollision (coll),
        .i_GameStart   (start),
        .o_HitPulse    (hit_pulse),
        .o_Lives       (lives),
        .o_Invincible  (invinc),
        .o_GameOver    (game_over),
        .o_SpriteOn    (sprite_on)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: game mode, lives, ticks left in the window, ticks spent in it.
    typedef enum int {M_IDLE, M_PLAY, M_INV, M_OVER} mode_t;
    mode_t m_mode;
    int    m_lives;
    int    m_pulse;
    int    m_left;
    int    m_elapsed;

    function automatic int m_sprite();
        if (BLINK && m_mode == M_INV) return (m_elapsed / BLINK_P) % 2;
        return 1;
    endfunction

    task automatic model_reset();
        m_mode    = M_IDLE;
        m_lives   = INIT_LIVES;
        m_pulse   = 0;
        m_left    = 0;
        m_elapsed = 0;
    endtask

    task automatic model_clock(input bit r, input bit t, input bit c, input bit s);
        m_pulse = 0;
        if (r) begin
            model_reset();
        end else if (s && (m_mode == M_IDLE || m_mode == M_OVER)) begin
            m_mode  = M_PLAY;
            m_lives = INIT_LIVES;
        end else if (m_mode == M_PLAY && t && c && m_lives >= 1) begin
            m_pulse = 1;
            m_lives = m_lives - 1;
            if (m_lives == 0) begin
                m_mode = M_OVER;
            end else begin
                m_mode    = M_INV;
                m_left    = INV_FRAMES;
                m_elapsed = 0;
            end
        end else if (m_mode == M_INV && t) begin
            m_left    = m_left - 1;
            m_elapsed = m_elapsed + 1;
            if (m_left == 0) m_mode = M_PLAY;
        end
    endtask

    task automatic compare_all();
        check("hit_pulse", 32'(hit_pulse), 32'(m_pulse));
        check("lives", 32'(lives), 32'(m_lives));
        check("invincible", 32'(invinc), 32'(m_mode == M_INV));
        check("game_over", 32'(game_over), 32'(m_mode == M_OVER));
        check("sprite_on", 32'(sprite_on), 32'(m_sprite()));
    endtask

    // Called #1 after a rising edge; drives inputs, clocks once, compares.
    task automatic step(input bit r, input bit t, input bit c, input bit s);
        rst   = r;
        tick  = t;
        coll  = c;
        start = s;
        @(posedge clk);
        model_clock(r, t, c, s);
        #1;
        compare_all();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pulse"}, 32'(hit_pulse), 32'd0);
        check({tag, "_lives"}, 32'(lives), 32'(INIT_LIVES));
        check({tag, "_inv"}, 32'(invinc), 32'd0);
        check({tag, "_over"}, 32'(game_over), 32'd0);
        check({tag, "_sprite"}, 32'(sprite_on), 32'd1);
    endtask

    int inv_ticks;
    int pulses;

    initial begin
        rst   = 1'b1;
        tick  = 1'b0;
        coll  = 1'b0;
        start = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");

        repeat (3) step(0, 1, 1, 0);
        step(0, 0, 0, 1);
        check("start_lives", 32'(lives), 32'(INIT_LIVES));

        // Collision without a frame tick never counts.
        repeat (100) step(0, 0, 1, 0);
        check("no_tick_lives", 32'(lives), 32'(INIT_LIVES));

        step(0, 1, 1, 0);
        check("hit1_pulse", 32'(hit_pulse), 32'd1);
        check("hit1_lives", 32'(lives), 32'd2);
        check("hit1_inv", 32'(invinc), 32'd1);
        step(0, 0, 1, 0);
        check("hit1_pulse_once", 32'(hit_pulse), 32'd0);

        // Overlap held through the whole window.
        inv_ticks = 0;
        pulses    = 0;
        for (int i = 0; i < INV_FRAMES; i++) begin
            if (invinc) inv_ticks++;
            check("blink_tick", 32'(sprite_on),
                  BLINK ? 32'((i / BLINK_P) % 2) : 32'd1);
            step(0, 1, 1, 0);
            pulses += int'(hit_pulse);
            step(0, 0, 1, 0);
        end
        check("inv_tick_count", 32'(inv_ticks), 32'(INV_FRAMES));
        check("inv_no_rehit", 32'(pulses), 32'd0);
        check("inv_end", 32'(invinc), 32'd0);
        step(0, 1, 1, 0);
        check("hit2_lives", 32'(lives), 32'd1);

        repeat (INV_FRAMES) step(0, 1, 1, 0);
        step(0, 1, 1, 0);
        check("hit3_lives", 32'(lives), 32'd0);
        check("hit3_over", 32'(game_over), 32'd1);
        repeat (20) step(0, 1, 1, 0);
        check("over_hold", 32'(lives), 32'd0);
        step(0, 1, 1, 1);
        check("restart_lives", 32'(lives), 32'(INIT_LIVES));
        check("restart_over", 32'(game_over), 32'd0);

        // Asynchronous reset in the middle of a window.
        step(0, 1, 1, 0);
        repeat (10) step(0, 1, 0, 0);
        rst = 1'b1;
        #1;
        model_reset();
        check_reset_vals("rst_async");
        step(1, 1, 1, 0);
        repeat (10) step(0, 1, 1, 0);
        check("idle_hold", 32'(lives), 32'(INIT_LIVES));

        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 39) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
